// File: rtl/scan_ser_if.sv
// Scan serializer port bundle: frame request/control in, serialized beats out.
interface scan_ser_if #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned LANES = 1
);
  logic             en;
  logic             cont;
  logic [WIDTH-1:0] scan_data;
  logic [LANES-1:0] scan_out;
  logic             scan_valid;
  logic             scan_done;

  modport master (output en, cont, scan_data, input scan_out, scan_valid, scan_done);
  modport slave  (input en, cont, scan_data, output scan_out, scan_valid, scan_done);
endinterface

// File: rtl/scan_ser.sv
// Captures a WIDTH-bit word on the rising edge of en and shifts it out LSB-first,
// LANES bits per beat. Define SCAN_PARITY_EN to append an even-parity beat.
module scan_ser #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned LANES = 1
) (
  input  logic      clk,
  input  logic      rst,
  scan_ser_if.slave bus
);

  localparam int unsigned BEATS = (WIDTH + LANES - 1) / LANES;
  localparam int unsigned CW    = $clog2(BEATS + 1);
  localparam int unsigned SW    = BEATS * LANES;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

`ifdef SCAN_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t          state_q, state_d;
  logic [SW-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic            last_en_q;
  logic            start;
  logic            load;
  logic            clear;
  logic [LANES-1:0] out_d;
  logic            valid_d;
  logic            done_d;
`ifdef SCAN_PARITY_EN
  logic            par_q, par_d;
`endif

  assign start = bus.en & ~last_en_q;

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      beat_q         <= '0;
      last_en_q      <= 1'b0;
      bus.scan_out   <= '0;
      bus.scan_valid <= 1'b0;
      bus.scan_done  <= 1'b0;
`ifdef SCAN_PARITY_EN
      par_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      beat_q         <= beat_d;
      last_en_q      <= bus.en;
      bus.scan_out   <= out_d;
      bus.scan_valid <= valid_d;
      bus.scan_done  <= done_d;
`ifdef SCAN_PARITY_EN
      par_q          <= par_d;
`endif
    end
  end

  // Next state; outputs are decoded from the next state so they register in step
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    beat_d  = beat_q;
    load    = 1'b0;
    clear   = 1'b0;
    out_d   = '0;
    valid_d = 1'b0;
    done_d  = 1'b0;
`ifdef SCAN_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) load = 1'b1;
      end
      SHIFT: begin
        if (!bus.en) begin
          clear = 1'b1;
        end else if (beat_q == LAST_BEAT) begin
`ifdef SCAN_PARITY_EN
          state_d = PAR;
          shreg_d = shreg_q >> LANES;
          beat_d  = beat_q + CW'(1);
`else
          if (bus.cont) load = 1'b1;
          else          clear = 1'b1;
`endif
        end else begin
          shreg_d = shreg_q >> LANES;
          beat_d  = beat_q + CW'(1);
        end
      end
`ifdef SCAN_PARITY_EN
      PAR: begin
        if (bus.en && bus.cont) load = 1'b1;
        else                    clear = 1'b1;
      end
`endif
      default: clear = 1'b1;
    endcase

    // A reload zero-extends the word so pad bits in the last beat read as 0
    if (load) begin
      state_d = SHIFT;
      shreg_d = SW'(bus.scan_data);
      beat_d  = '0;
`ifdef SCAN_PARITY_EN
      par_d   = ^bus.scan_data;
`endif
    end else if (clear) begin
      state_d = IDLE;
      shreg_d = '0;
      beat_d  = '0;
    end

    case (state_d)
      SHIFT: begin
        out_d   = shreg_d[LANES-1:0];
        valid_d = 1'b1;
`ifndef SCAN_PARITY_EN
        done_d  = (beat_d == LAST_BEAT);
`endif
      end
`ifdef SCAN_PARITY_EN
      PAR: begin
        out_d   = LANES'(par_d);
        valid_d = 1'b1;
        done_d  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_scan_ser.sv
// Randomized bench for scan_ser: two instances (1 lane, 4 lanes) checked every cycle
// against a frame-position model, plus literal beat patterns for 19'h5A5A5.
module tb_scan_ser;

  localparam int unsigned W = 19;
`ifdef SCAN_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic cont;
  logic [W-1:0] data;
  bit   pin_on;
  bit   done_pin;
  logic done_exp;

  always #5 clk = ~clk;

  scan_ser_if #(.WIDTH(W), .LANES(1)) bus1 ();
  scan_ser_if #(.WIDTH(W), .LANES(4)) bus4 ();

  assign bus1.en = en;
  assign bus1.cont = cont;
  assign bus1.scan_data = data;
  assign bus4.en = en;
  assign bus4.cont = cont;
  assign bus4.scan_data = data;

  scan_ser #(.WIDTH(W), .LANES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  scan_ser #(.WIDTH(W), .LANES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // Model: position of each instance inside its current frame (-1 = no frame)
  int         pos [2] = '{-1, -1};
  logic [W-1:0] word [2];
  bit         m_last_en = 1'b0;

  function automatic int lanes_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int frame_len(input int i);
    int b;
    b = (W + lanes_of(i) - 1) / lanes_of(i);
    return HAS_PAR ? b + 1 : b;
  endfunction

  // Expected {out[3:0], valid, done} for instance i
  function automatic logic [5:0] expect_of(input int i);
    int l;
    int b;
    logic [31:0] v;
    logic [3:0] o;
    logic d;
    l = lanes_of(i);
    b = (W + l - 1) / l;
    if (pos[i] < 0) return 6'd0;
    if (pos[i] < b) begin
      v = (32'(word[i]) >> (pos[i] * l)) & ((32'd1 << l) - 32'd1);
      o = 4'(v);
      d = !HAS_PAR && (pos[i] == b - 1);
    end else begin
      o = 4'(^word[i]);
      d = 1'b1;
    end
    return {o, 1'b1, d};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pos[0] = -1;
      pos[1] = -1;
      m_last_en = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pos[i] < 0) begin
          if (en && !m_last_en) begin
            word[i] = data;
            pos[i] = 0;
          end
        end else if (!en) begin
          pos[i] = -1;
        end else if (pos[i] == frame_len(i) - 1) begin
          if (cont) begin
            word[i] = data;
            pos[i] = 0;
          end else begin
            pos[i] = -1;
          end
        end else begin
          pos[i] = pos[i] + 1;
        end
      end
      m_last_en = en;
    end
  end

  int tests = 0;
  int fails = 0;
  int k1 = 0;
  int k4 = 0;
  logic [3:0] lit4 [5] = '{4'h5, 4'hA, 4'h5, 4'hA, 4'h5};
  logic       lit1 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // Single compare process, sampled on the falling edge
  always @(negedge clk) begin
    logic [5:0] e;
    logic [5:0] a;
    for (int i = 0; i < 2; i++) begin
      e = expect_of(i);
      a = (i == 0) ? {4'(bus1.scan_out), bus1.scan_valid, bus1.scan_done}
                   : {4'(bus4.scan_out), bus4.scan_valid, bus4.scan_done};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL model_lanes%0d t=%0t got out=%h valid=%b done=%b, want out=%h valid=%b done=%b",
                 lanes_of(i), $time, a[5:2], a[1], a[0], e[5:2], e[1], e[0]);
      end
    end
    if (pin_on) begin
      if (bus4.scan_valid && k4 < 5) begin
        tests++;
        if (bus4.scan_out !== lit4[k4]) begin
          fails++;
          $display("FAIL lit_lanes4 beat%0d got %h want %h", k4, bus4.scan_out, lit4[k4]);
        end
        k4++;
      end
      if (bus1.scan_valid && k1 < 8) begin
        tests++;
        if (bus1.scan_out !== lit1[k1]) begin
          fails++;
          $display("FAIL lit_lanes1 beat%0d got %b want %b", k1, bus1.scan_out, lit1[k1]);
        end
        k1++;
      end
    end else begin
      k1 = 0;
      k4 = 0;
    end
    if (done_pin && bus1.scan_done) begin
      tests++;
      if (bus1.scan_out !== done_exp) begin
        fails++;
        $display("FAIL done_beat got %b want %b", bus1.scan_out, done_exp);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cont = 1'b0; data = '0;
    pin_on = 1'b0; done_pin = 1'b0; done_exp = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    // Single frame of 19'h5A5A5
    data = 19'h5A5A5; pin_on = 1'b1; en = 1'b1;
    cyc(26);
    en = 1'b0; pin_on = 1'b0;
    cyc(3);

    // Continuous mode with data changing mid-frame
    cont = 1'b1; data = 19'h00001; en = 1'b1;
    cyc(6);
    data = 19'h00002;
    cyc(40);
    cont = 1'b0;
    cyc(25);
    en = 1'b0;
    cyc(3);

    // Abort mid-frame, then re-raise
    data = W'($urandom); en = 1'b1;
    cyc(8);
    en = 1'b0;
    cyc(3);
    en = 1'b1;
    cyc(25);
    en = 1'b0;
    cyc(2);

    // Reset mid-frame with en held
    en = 1'b1;
    cyc(4);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(25);
    en = 1'b0;
    cyc(2);

    // Final-beat value: parity beat when present, else top data bit (0 for both words)
    for (int j = 0; j < 2; j++) begin
      data = (j == 0) ? 19'h00001 : 19'h00003;
      done_exp = HAS_PAR && (j == 0);
      done_pin = 1'b1; en = 1'b1;
      cyc(24);
      en = 1'b0; done_pin = 1'b0;
      cyc(2);
    end

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 24) == 0) en = ~en;
      if ($urandom_range(0, 15) == 0) cont = ~cont;
      data = W'($urandom);
      cyc(1);
    end

    rst = 1'b0; en = 1'b0;
    cyc(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
